// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Optional build macro MULDIV_FAST_ZERO_EN is consumed by muldiv_seq_unit.
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t;

  localparam logic [MD_XLEN-1:0] INT_MIN  = {1'b1, {(MD_XLEN-1){1'b0}}};
  localparam logic [MD_XLEN-1:0] ALL_ONES = {MD_XLEN{1'b1}};

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide step
// on a 2*XLEN accumulator ({hi, lo} = {partial, multiplier} or {rem, quot}).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;

  // The divide trial uses XLEN+1 bits of the shifted remainder so the bit shifted out is not lost.
  always_comb begin
    sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
    trial = acc_in[2*XLEN-1:XLEN-1] - {1'b0, operand};
    if (is_div) begin
      acc_out = trial[XLEN] ? {acc_in[2*XLEN-2:0], 1'b0}
                            : {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
    end else begin
      acc_out = {sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Sequential RISC-V M-extension unit: XLEN-cycle multiply/divide with valid/ready handshake.
// Build option: define MULDIV_FAST_ZERO_EN to short-circuit zero-operand operations.
module muldiv_seq_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  md_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_q;
  logic              neg_r;
  logic              is_div_q;

  logic            req_div, req_rem, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, fast_zero;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  // Request decode: signedness, magnitudes and the cases that skip the iteration loop.
  always_comb begin
    req_div  = req_op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    req_rem  = req_op inside {MD_REM, MD_REMU};
    a_signed = req_op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_signed = req_op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    a_neg    = a_signed && req_a[XLEN-1];
    b_neg    = b_signed && req_b[XLEN-1];
    abs_a    = a_neg ? -req_a : req_a;
    abs_b    = b_neg ? -req_b : req_b;
    div_zero = req_div && (req_b == '0);
    div_ovf  = req_div && b_signed && (req_a == INT_MIN) && (req_b == ALL_ONES);
`ifdef MULDIV_FAST_ZERO_EN
    fast_zero = req_div ? ((req_a == '0) && (req_b != '0))
                        : ((req_a == '0) || (req_b == '0));
`else
    fast_zero = 1'b0;
`endif
    special_res = '0;
    if (div_zero)     special_res = req_rem ? req_a : ALL_ONES;
    else if (div_ovf) special_res = req_rem ? '0 : INT_MIN;
  end

  assign is_div_q = op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div_q),
    .acc_in  (acc),
    .operand (opnd_q),
    .acc_out (acc_step)
  );

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_res;

  always_comb begin
    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                       fix_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = quot;
      default:                      fix_res = rem;
    endcase
  end

  // Control FSM; flush beats every other transition and drops any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      acc         <= '0;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && req_valid) begin
            op_q      <= req_op;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (div_zero || div_ovf || fast_zero) begin
              state       <= DONE;
              resp_valid  <= 1'b1;
              resp_result <= special_res;
            end else begin
              state  <= CALC;
              cnt    <= '0;
              acc    <= {{XLEN{1'b0}}, (req_div ? abs_a : abs_b)};
              opnd_q <= req_div ? abs_b : abs_a;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            resp_result <= fix_res;
            resp_valid  <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (flush || resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_seq_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  muldiv_seq_unit dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: the architectural definition of each operation in 64-bit arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return ALL_ONES;
        if (a == INT_MIN && b == ALL_ONES) return INT_MIN;
        return 32'(ia / ib);
      end
      MD_DIVU: return (b == 0) ? ALL_ONES : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == INT_MIN && b == ALL_ONES) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_div = op[2];
    if (is_div && b == 0) return 1;
    if ((op == MD_DIV || op == MD_REM) && a == INT_MIN && b == ALL_ONES) return 1;
`ifdef MULDIV_FAST_ZERO_EN
    if (!is_div && (a == 0 || b == 0)) return 1;
    if (is_div && a == 0) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, measure latency, hold off the response for bp cycles, then consume it.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int bp, input string tag);
    int          lat;
    int          guard;
    bit          ready_bad;
    bit          hold_bad;
    logic [31:0] res0;
    guard = 0;
    while (!req_ready && guard < 60) begin
      @(posedge clk); #1; guard++;
    end
    checkOutput({tag, "/idle"}, {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
    lat = 1; ready_bad = 1'b0;
    while (!resp_valid && lat < 100) begin
      if (req_ready) ready_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (req_ready) ready_bad = 1'b1;
    checkOutput({tag, "/lat"}, 32'(lat), 32'(refLatency(op, a, b)));
    checkOutput({tag, "/res"}, resp_result, refResult(op, a, b));
    checkOutput({tag, "/busy_ready"}, {30'b0, busy, ready_bad}, 32'b10);
    res0 = resp_result; hold_bad = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_result !== res0 || req_ready !== 1'b0) hold_bad = 1'b1;
    end
    if (bp > 0) checkOutput({tag, "/hold"}, {31'b0, hold_bad}, 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput({tag, "/release"}, {29'b0, resp_valid, req_ready, busy}, 32'b010);
  endtask

  initial begin
    int quiet_bad;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    flush = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset/outputs", {29'b0, req_ready, resp_valid, busy}, 32'b100);
    checkOutput("reset/result", resp_result, 32'h0);
    @(negedge clk); rst = 1'b0;

    applyStimulus(MD_MUL,    32'hFFFF_FFFF, 32'd7,        0, "mul_neg1x7");
    applyStimulus(MD_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 0, "mulh");
    applyStimulus(MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 0, "mulhsu");
    applyStimulus(MD_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 0, "mulhu");
    applyStimulus(MD_DIV,    32'hFFFF_FFF9, 32'd2,        0, "div_m7_2");
    applyStimulus(MD_REM,    32'hFFFF_FFF9, 32'd2,        0, "rem_m7_2");
    applyStimulus(MD_DIVU,   32'hFFFF_FFF9, 32'd2,        0, "divu");
    applyStimulus(MD_REMU,   32'hFFFF_FFF9, 32'd2,        0, "remu");
    applyStimulus(MD_DIV,    32'd5,         32'd0,        0, "div_by0");
    applyStimulus(MD_REM,    32'd5,         32'd0,        0, "rem_by0");
    applyStimulus(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    applyStimulus(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    applyStimulus(MD_MULHU,  32'h1234_5678, 32'h9ABC_DEF0, 10, "backpressure");

    // Flush ignored in IDLE even with a request present.
    @(negedge clk); flush = 1'b1; req_valid = 1'b1; req_op = MD_MUL; req_a = 32'd3; req_b = 32'd3;
    @(posedge clk); #1; flush = 1'b0; req_valid = 1'b0;
    checkOutput("flush_idle/not_accepted", {30'b0, req_ready, busy}, 32'b10);

    // Flush at CALC iteration 10.
    @(negedge clk); req_valid = 1'b1; req_op = MD_MUL; req_a = 32'd9; req_b = 32'd9;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checkOutput("flush_calc/idle", {29'b0, req_ready, resp_valid, busy}, 32'b100);
    quiet_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid) quiet_bad++;
    end
    checkOutput("flush_calc/no_resp", 32'(quiet_bad), 32'd0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk); req_valid = 1'b1; req_op = MD_DIVU; req_a = 32'd1000; req_b = 32'd7;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst = 1'b1; #1;
    checkOutput("async_rst/outputs", {29'b0, req_ready, resp_valid, busy}, 32'b100);
    checkOutput("async_rst/result", resp_result, 32'h0);
    @(negedge clk); rst = 1'b0;
    applyStimulus(MD_MUL, 32'd3, 32'd4, 0, "after_rst_mul");

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pickOperand();
      b  = pickOperand();
      applyStimulus(op, a, b, $urandom_range(0, 3), $sformatf("rand%0d_op%0d", i, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
Iterative multi-cycle M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) serving as the sequential responder to the core's execute stage. The core issues operands through a valid/ready request channel and stalls until the result returns on a valid/ready response channel. Radix-2 shift-add multiply and restoring divide. One operation in flight.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.
CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit idle; accepts a request this cycle.
req_op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
req_a  in  XLEN  rs1 operand.
req_b  in  XLEN  rs2 operand.
flush  in  1  abort the in-flight operation (pipeline kill).
resp_valid  out  1  result available.
resp_ready  in  1  consumer takes the result.
resp_result  out  XLEN  result.
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; req_ready=1; resp_valid=0; resp_result=0; busy=0; counter and internal registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE: req_ready=1. When req_valid=1, the unit latches op, a, b and records the sign flags.
  - Signed ops take absolute values.
  - MULHSU: only a is treated as signed.
  - The target state depends on the request:
    - Divide by zero: go to DONE. The result is all-ones for DIV/DIVU and req_a for REM/REMU.
    - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): go to DONE. DIV returns 0x80000000; REM returns 0.
    - All other requests: go to CALC with counter=0.
- CALC: one iteration per cycle, exactly XLEN cycles. The counter counts 0..XLEN-1, and the unit goes to FIX on the last iteration.
  - Multiply: 2*XLEN accumulator. If the multiplier LSB=1, add the multiplicand into the upper half, then shift right 1.
  - Divide: shift the {rem,quot} pair left 1. Trial-subtract the divisor; if the result is non-negative, keep it and set the quotient LSB.
- FIX: one cycle. Apply sign correction by two's-complement negation:
  - product: when sign_a XOR sign_b;
  - quotient: when signs differ;
  - remainder: takes the dividend's sign.
  - Then select the field: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits; DIV* take the quotient; REM* take the remainder.
  - resp_result is registered here. Go to DONE.
- DONE: resp_valid=1 and resp_result is held stable. If resp_ready=1, go to IDLE. resp_valid deasserts in the next cycle.
- Latency from the acceptance edge to resp_valid:
  - Normal operations: XLEN+2 cycles (34).
  - Special-case divides: 1 cycle.
- A request cannot be accepted in the same cycle a response is consumed: req_ready is 0 in DONE.
- flush:
  - In CALC/FIX/DONE: go to IDLE next edge; resp_valid=0; the result is discarded.
  - In IDLE: no effect. flush has priority over req_valid, so no request is accepted in a flush cycle.
- req_op/req_a/req_b are don't-care outside the acceptance cycle. Internal copies are immune to input changes.

Optional Feature:
MULDIV_FAST_ZERO_EN:
- Defined: in IDLE, if a multiply has req_a=0 or req_b=0, or a DIV/DIVU/REM/REMU has req_a=0 (with req_b≠0), go directly to DONE with result 0. Latency is 1 cycle.
- Undefined: these cases take the full XLEN+2 path and produce the same value 0.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings MD_MUL..MD_REMU (3-bit);
  - state enum IDLE/CALC/FIX/DONE;
  - constants INT_MIN (0x80000000 at XLEN=32) and ALL_ONES.
- Sub-module muldiv_step is natural: a combinational single-iteration datapath (add-shift / subtract-shift), selected by an is_div input, with a 2*XLEN accumulator in and out. The top level keeps the FSM, counter, sign handling and handshake.

Test Plan:
- MUL a=0xFFFFFFFF (-1), b=7 -> result 0xFFFFFFF9; resp_valid exactly 34 cycles after acceptance; req_ready=0 throughout.
- MULH/MULHSU/MULHU, a=0x80000000, b=0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- DIV by zero with a=5 -> 0xFFFFFFFF; REM by zero with a=5 -> 5; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0; each resp_valid 1 cycle after acceptance.
- Response backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_result are stable; req_ready=0. After resp_ready=1, back in IDLE next cycle.
- Robustness: flush at CALC iteration 10 -> IDLE next edge, no resp_valid. Assert rst mid-CALC -> outputs return to reset values immediately without waiting for a clock edge. The next request, MUL 3*4, returns 12.
